// File: rtl/rename_pkg.sv
// Shared types and sizing for the register-rename map table.
//   arch_t    : architectural register index
//   phy_t     : physical register index
//   map_t     : one physical name per architectural register
//   ren_out_t : per-lane rename result carried by the output stage
//   reset_map : identity table loaded on reset and clear
package rename_pkg;

  localparam int unsigned ArchRegs = 8;   // architectural registers
  localparam int unsigned BitVecW  = 16;  // physical registers, same as the free list
  localparam int unsigned RenIo    = 4;   // rename lanes, same as free list alloc ports
  localparam bit          HwPhy0   = 1'b1; // arch 0 is hardwired to phy 0

  localparam int unsigned Aw = $clog2(ArchRegs);
  localparam int unsigned Pw = $clog2(BitVecW);
  localparam int unsigned Lw = (RenIo > 1) ? $clog2(RenIo) : 1;

  typedef logic [Aw-1:0] arch_t;
  typedef logic [Pw-1:0] phy_t;
  typedef phy_t [ArchRegs-1:0] map_t;

  typedef struct packed {
    logic dst_vld;
    phy_t dst_phy;
    phy_t old_phy;
    phy_t src_a_phy;
    phy_t src_b_phy;
  } ren_out_t;

  function automatic map_t reset_map();
    map_t m;
    for (int unsigned r = 0; r < ArchRegs; r++) begin
      m[r] = phy_t'(r);
    end
    return m;
  endfunction

endpackage

// File: rtl/rename_map_table_if.sv
// Bundle of the rename stage's lane inputs, free-list alloc handshake, checkpoint
// controls and registered output group.
//   slave  : the rename map table's view
//   master : the surrounding pipeline / free list / testbench view
interface rename_map_table_if;
  import rename_pkg::*;

  // Upstream lanes
  logic [RenIo-1:0]  in_vld;
  logic [RenIo-1:0]  in_rdy;
  logic [RenIo-1:0]  in_dst_vld;
  arch_t [RenIo-1:0] in_dst_arch;
  arch_t [RenIo-1:0] in_src_a_arch;
  arch_t [RenIo-1:0] in_src_b_arch;

  // Free list
  logic [RenIo-1:0]  alloc_req;
  logic [RenIo-1:0]  alloc_vld;
  phy_t [RenIo-1:0]  alloc_phy;

  // Checkpoint
  logic              ckpt_save;
  logic              ckpt_restore;

  // Downstream group
  logic [RenIo-1:0]  out_vld;
  logic              out_rdy;
  logic [RenIo-1:0]  out_dst_vld;
  phy_t [RenIo-1:0]  out_dst_phy;
  phy_t [RenIo-1:0]  out_old_phy;
  phy_t [RenIo-1:0]  out_src_a_phy;
  phy_t [RenIo-1:0]  out_src_b_phy;

  modport slave (
    input  in_vld, in_dst_vld, in_dst_arch, in_src_a_arch, in_src_b_arch,
    output in_rdy,
    output alloc_req,
    input  alloc_vld, alloc_phy,
    input  ckpt_save, ckpt_restore,
    output out_vld, out_dst_vld, out_dst_phy, out_old_phy, out_src_a_phy, out_src_b_phy,
    input  out_rdy
  );

  modport master (
    output in_vld, in_dst_vld, in_dst_arch, in_src_a_arch, in_src_b_arch,
    input  in_rdy,
    input  alloc_req,
    output alloc_vld, alloc_phy,
    output ckpt_save, ckpt_restore,
    input  out_vld, out_dst_vld, out_dst_phy, out_old_phy, out_src_a_phy, out_src_b_phy,
    output out_rdy
  );

endinterface

// File: rtl/rename_bypass_mux.sv
// Resolves one operand's physical name for one lane: the committed table value,
// overridden by the newest earlier lane in the same group that renames the same
// architectural register. Arch 0 resolves to phy 0 when hardwired.
//   tbl_phy_i   : map table entry for arch_i
//   arch_i      : architectural register being looked up
//   need_i      : per-lane "accepted and allocating" mask of the group
//   dst_arch_i  : per-lane destination arch registers
//   alloc_phy_i : per-lane newly allocated physical names
//   lane_i      : index of the lane doing the lookup (only lanes below it count)
//   phy_o       : resolved physical name
module rename_bypass_mux
  import rename_pkg::*;
(
  input  phy_t              tbl_phy_i,
  input  arch_t             arch_i,
  input  logic [RenIo-1:0]  need_i,
  input  arch_t [RenIo-1:0] dst_arch_i,
  input  phy_t [RenIo-1:0]  alloc_phy_i,
  input  logic [Lw-1:0]     lane_i,
  output phy_t              phy_o
);

  always_comb begin
    phy_o = tbl_phy_i;
    // Ascending scan so the highest earlier lane wins.
    for (int unsigned j = 0; j < RenIo; j++) begin
      if ((Lw'(j) < lane_i) && need_i[j] && (dst_arch_i[j] == arch_i)) begin
        phy_o = alloc_phy_i[j];
      end
    end
    if (HwPhy0 && (arch_i == '0)) begin
      phy_o = '0;
    end
  end

endmodule

// File: rtl/rename_map_table.sv
// Register-rename map table with a single branch checkpoint. Each cycle it accepts a
// contiguous prefix of up to RenIo lanes, allocates destinations from the free list,
// resolves sources with intra-group bypass and registers the results into a
// valid/ready output stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (identity map, empty output stage)
//   ren_if     : lanes in, free-list alloc, checkpoint controls, output group
module rename_map_table
  import rename_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  input logic              clr,
  rename_map_table_if.slave ren_if
);

  logic                  stg_free;
  logic [RenIo-1:0]      need;
  logic [RenIo-1:0]      acc;
  logic [RenIo-1:0]      acc_need;
  logic [RenIo-1:0]      alloc_req;
  phy_t [RenIo-1:0]      src_a_phy;
  phy_t [RenIo-1:0]      src_b_phy;
  phy_t [RenIo-1:0]      old_phy;

  map_t                  map_q, map_d;
  map_t                  ckpt_q, ckpt_d;
  logic [RenIo-1:0]      out_vld_q, out_vld_d;
  ren_out_t [RenIo-1:0]  out_q, out_d;

  // Acceptance chain: a lane goes only if every earlier lane went, so allocations
  // are handed out strictly in lane order and a refused lane blocks the rest.
  always_comb begin : accept_chain
    logic ok;
    need      = '0;
    alloc_req = '0;
    acc       = '0;
    stg_free  = ~(|out_vld_q) | ren_if.out_rdy;
    ok        = stg_free & ~ren_if.ckpt_restore;
    for (int unsigned i = 0; i < RenIo; i++) begin
      need[i]      = ren_if.in_vld[i] & ren_if.in_dst_vld[i] &
                     ~(HwPhy0 & (ren_if.in_dst_arch[i] == '0));
      alloc_req[i] = ok & need[i];
      ok           = ok & ren_if.in_vld[i] & (~need[i] | ren_if.alloc_vld[i]);
      acc[i]       = ok;
    end
  end

  assign acc_need         = acc & need;
  assign ren_if.in_rdy    = acc;
  assign ren_if.alloc_req = alloc_req;

  for (genvar g = 0; g < RenIo; g++) begin : g_lane
    rename_bypass_mux u_src_a (
      .tbl_phy_i   (map_q[ren_if.in_src_a_arch[g]]),
      .arch_i      (ren_if.in_src_a_arch[g]),
      .need_i      (acc_need),
      .dst_arch_i  (ren_if.in_dst_arch),
      .alloc_phy_i (ren_if.alloc_phy),
      .lane_i      (Lw'(g)),
      .phy_o       (src_a_phy[g])
    );

    rename_bypass_mux u_src_b (
      .tbl_phy_i   (map_q[ren_if.in_src_b_arch[g]]),
      .arch_i      (ren_if.in_src_b_arch[g]),
      .need_i      (acc_need),
      .dst_arch_i  (ren_if.in_dst_arch),
      .alloc_phy_i (ren_if.alloc_phy),
      .lane_i      (Lw'(g)),
      .phy_o       (src_b_phy[g])
    );

    // Previous mapping of the destination, returned to the free list at commit.
    rename_bypass_mux u_old (
      .tbl_phy_i   (map_q[ren_if.in_dst_arch[g]]),
      .arch_i      (ren_if.in_dst_arch[g]),
      .need_i      (acc_need),
      .dst_arch_i  (ren_if.in_dst_arch),
      .alloc_phy_i (ren_if.alloc_phy),
      .lane_i      (Lw'(g)),
      .phy_o       (old_phy[g])
    );

    assign ren_if.out_dst_vld[g]   = out_q[g].dst_vld;
    assign ren_if.out_dst_phy[g]   = out_q[g].dst_phy;
    assign ren_if.out_old_phy[g]   = out_q[g].old_phy;
    assign ren_if.out_src_a_phy[g] = out_q[g].src_a_phy;
    assign ren_if.out_src_b_phy[g] = out_q[g].src_b_phy;
  end

  assign ren_if.out_vld = out_vld_q;

  always_comb begin : next_state
    map_d     = map_q;
    ckpt_d    = ckpt_q;
    out_vld_d = out_vld_q;
    out_d     = out_q;

    // Ascending order: the highest lane wins a same-arch collision.
    for (int unsigned i = 0; i < RenIo; i++) begin
      if (acc_need[i]) begin
        map_d[ren_if.in_dst_arch[i]] = ren_if.alloc_phy[i];
      end
    end

    // Save captures the table including this cycle's renames; restore wins.
    if (ren_if.ckpt_restore) begin
      map_d = ckpt_q;
    end else if (ren_if.ckpt_save) begin
      ckpt_d = map_d;
    end

    if (ren_if.ckpt_restore) begin
      out_vld_d = '0;
    end else if (stg_free) begin
      out_vld_d = acc;
      for (int unsigned i = 0; i < RenIo; i++) begin
        out_d[i] = '0;
        if (acc[i]) begin
          out_d[i].dst_vld   = need[i];
          out_d[i].dst_phy   = need[i] ? ren_if.alloc_phy[i] : '0;
          out_d[i].old_phy   = need[i] ? old_phy[i] : '0;
          out_d[i].src_a_phy = src_a_phy[i];
          out_d[i].src_b_phy = src_b_phy[i];
        end
      end
    end

    if (clr) begin
      map_d     = reset_map();
      ckpt_d    = reset_map();
      out_vld_d = '0;
      out_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q     <= reset_map();
      ckpt_q    <= reset_map();
      out_vld_q <= '0;
      out_q     <= '0;
    end else begin
      map_q     <= map_d;
      ckpt_q    <= ckpt_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
    end
  end

endmodule
